// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB3 master and its address decoder.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Window decoder: slave i owns BASE_ADDR + i*2^WIN_LOG2 for 2^WIN_LOG2 bytes.
module apb_addr_decoder #(
  parameter int                ADDR_W    = 32,
  parameter int                NSLV      = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                WIN_LOG2  = 8
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [NSLV-1:0]   sel_o,
  output logic              hit_o
);

  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] index;

  always_comb begin
    offset = addr_i - BASE_ADDR;
    index  = offset >> WIN_LOG2;
    // Below BASE_ADDR the subtraction wraps, so the explicit compare rejects it
    hit_o  = (addr_i >= BASE_ADDR) && (index < ADDR_W'(NSLV));
    sel_o  = '0;
    for (int i = 0; i < NSLV; i++) begin
      sel_o[i] = hit_o && (index == ADDR_W'(i));
    end
  end

endmodule

// File: rtl/apb3_master_mux.sv
// APB3 bridge master: one command at a time onto NSLV address-windowed slaves,
// with wait states, PSLVERR, decode-miss and timeout responses.
module apb3_master_mux
  import apb_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                NSLV      = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                WIN_LOG2  = 8,
  parameter int                TIMEOUT   = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [ADDR_W-1:0]      cmd_addr,
  input  logic [DATA_W-1:0]      cmd_wdata,
  output logic                   rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic                   rsp_timeout,
  output logic [ADDR_W-1:0]      paddr,
  output logic                   pwrite,
  output logic [DATA_W-1:0]      pwdata,
  output logic [NSLV-1:0]        psel,
  output logic                   penable,
  input  logic [NSLV*DATA_W-1:0] prdata,
  input  logic [NSLV-1:0]        pready,
  input  logic [NSLV-1:0]        pslverr
);

  localparam int                TCNT_W   = (TIMEOUT > 0) ? clog2(TIMEOUT + 1) : 1;
  localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TIMEOUT);
  localparam logic [TCNT_W-1:0] TCNT_END = TCNT_W'(TIMEOUT - 1);

  apb_state_e          state_q, state_d;
  logic [NSLV-1:0]     psel_q, psel_d;
  logic                penable_q, penable_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic                pwrite_q, pwrite_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic                rsp_tmo_q, rsp_tmo_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic                miss_pend_q, miss_pend_d;

  logic [NSLV-1:0]     dec_sel;
  logic                dec_hit;
  logic                sel_pready;
  logic                sel_err;
  logic [DATA_W-1:0]   sel_rdata;
  logic                accept;
  logic                tmo_hit;

  apb_addr_decoder #(
    .ADDR_W   (ADDR_W),
    .NSLV     (NSLV),
    .BASE_ADDR(BASE_ADDR),
    .WIN_LOG2 (WIN_LOG2)
  ) u_dec (
    .addr_i(cmd_addr),
    .sel_o (dec_sel),
    .hit_o (dec_hit)
  );

  always_comb begin
    sel_pready = |(pready & psel_q);
    sel_err    = |(pslverr & psel_q);
    sel_rdata  = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (psel_q[i]) sel_rdata = sel_rdata | prdata[i*DATA_W +: DATA_W];
    end
  end

  assign cmd_ready = (state_q == ST_IDLE) || ((state_q == ST_ACCESS) && sel_pready);
  assign accept    = cmd_valid && cmd_ready;
  assign tmo_hit   = (TIMEOUT > 0) && (tcnt_q == TCNT_END);

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    tcnt_d      = tcnt_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_tmo_d   = 1'b0;
    rsp_rdata_d = '0;
    miss_pend_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (miss_pend_q) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
        tcnt_d    = '0;
      end
      ST_ACCESS: begin
        if (sel_pready) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = sel_err;
          rsp_rdata_d = (pwrite_q || sel_err) ? '0 : sel_rdata;
          state_d     = ST_IDLE;
          psel_d      = '0;
          penable_d   = 1'b0;
        end else if (tmo_hit) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_tmo_d   = 1'b1;
          state_d     = ST_IDLE;
          psel_d      = '0;
          penable_d   = 1'b0;
        end else if (tcnt_q != TCNT_MAX) begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      paddr_d   = cmd_addr;
      pwrite_d  = cmd_write;
      pwdata_d  = cmd_write ? cmd_wdata : '0;
      penable_d = 1'b0;
      if (dec_hit) begin
        state_d = ST_SETUP;
        psel_d  = dec_sel;
      end else begin
        state_d = ST_IDLE;
        psel_d  = '0;
        // A miss accepted while another response is leaving is reported one cycle later
        if (rsp_valid_d) begin
          miss_pend_d = 1'b1;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_tmo_q   <= 1'b0;
      rsp_rdata_q <= '0;
      tcnt_q      <= '0;
      miss_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_tmo_q   <= rsp_tmo_d;
      rsp_rdata_q <= rsp_rdata_d;
      tcnt_q      <= tcnt_d;
      miss_pend_q <= miss_pend_d;
    end
  end

  assign psel        = psel_q;
  assign penable     = penable_q;
  assign paddr       = paddr_q;
  assign pwrite      = pwrite_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_tmo_q;
  assign rsp_rdata   = rsp_rdata_q;

endmodule

// File: tb/tb_apb3_master_mux.sv
// Bench for apb3_master_mux: scripted scenarios against a small slave model,
// responses checked through an expected-response queue.
module tb_apb3_master_mux;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int NS  = 4;
  localparam int TMO = 16;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0]    cmd_addr;
  logic [DW-1:0]    cmd_wdata;
  logic             rsp_valid, rsp_err, rsp_timeout;
  logic [DW-1:0]    rsp_rdata;
  logic [AW-1:0]    paddr;
  logic             pwrite, penable;
  logic [DW-1:0]    pwdata;
  logic [NS-1:0]    psel, pready, pslverr;
  logic [NS*DW-1:0] prdata;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic          tmo;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  int          acc_cnt;
  int          wait_cfg[NS];
  logic        err_cfg[NS];
  logic [31:0] rdata_cfg[NS];

  apb3_master_mux #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .NSLV     (NS),
    .BASE_ADDR(32'h0),
    .WIN_LOG2 (8),
    .TIMEOUT  (TMO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .paddr      (paddr),
    .pwrite     (pwrite),
    .pwdata     (pwdata),
    .psel       (psel),
    .penable    (penable),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: selected slave waits wait_cfg ACCESS cycles (-1 = never ready);
  // unselected slaves drive hostile values that must be ignored.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          acc_cnt <= 0;
    else if (penable && !(|(pready & psel))) acc_cnt <= acc_cnt + 1;
    else                                   acc_cnt <= 0;
  end

  always_comb begin
    pready  = '0;
    pslverr = '0;
    prdata  = '0;
    for (int i = 0; i < NS; i++) begin
      if (psel[i]) begin
        pready[i]             = (wait_cfg[i] >= 0) && (acc_cnt >= wait_cfg[i]);
        pslverr[i]            = err_cfg[i];
        prdata[i*DW +: DW]    = rdata_cfg[i];
      end else begin
        pready[i]             = 1'b1;
        pslverr[i]            = 1'b1;
        prdata[i*DW +: DW]    = 32'hBAD0_0000 | i;
      end
    end
  end

  function automatic exp_t model(input logic w, input logic [31:0] a);
    exp_t        e;
    logic [31:0] idx;
    int          s;
    e.rdata = '0;
    e.err   = 1'b1;
    e.tmo   = 1'b0;
    idx     = a >> 8;
    if (idx < NS) begin
      s = int'(idx);
      if (wait_cfg[s] < 0 || wait_cfg[s] >= TMO) begin
        e.tmo = 1'b1;
      end else begin
        e.err = err_cfg[s];
        if (!w && !err_cfg[s]) e.rdata = rdata_cfg[s];
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (rsp_valid) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL rsp_unexpected: rdata=%h err=%b tmo=%b, no response expected",
                 rsp_rdata, rsp_err, rsp_timeout);
      end else begin
        mon_e = sb.pop_front();
        if (rsp_rdata !== mon_e.rdata || rsp_err !== mon_e.err || rsp_timeout !== mon_e.tmo) begin
          fails++;
          $display("FAIL rsp_data: got rdata=%h err=%b tmo=%b, expected rdata=%h err=%b tmo=%b",
                   rsp_rdata, rsp_err, rsp_timeout, mon_e.rdata, mon_e.err, mon_e.tmo);
        end
      end
    end
  end

  // Presents a command, waits (bounded) for acceptance, returns the cycle after the accept edge.
  task automatic drive_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                           output int acc_cyc);
    int n;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    sb.push_back(model(w, a));
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: addr=%h never accepted", a);
    end
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (psel !== 4'b0000 || penable !== 1'b0) begin
      fails++;
      $display("FAIL reset_apb_ctl: psel=%b penable=%b, required 0000/0", psel, penable);
    end
    tests++;
    if (paddr !== '0 || pwrite !== 1'b0 || pwdata !== '0) begin
      fails++;
      $display("FAIL reset_apb_data: paddr=%h pwrite=%b pwdata=%h, required 0", paddr, pwrite, pwdata);
    end
    tests++;
    if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0 || rsp_rdata !== '0) begin
      fails++;
      $display("FAIL reset_rsp: valid=%b err=%b tmo=%b rdata=%h, required 0",
               rsp_valid, rsp_err, rsp_timeout, rsp_rdata);
    end
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: cmd_ready=%b, required 1", cmd_ready);
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_write_zero_wait();
    int t;
    drive_cmd(1'b1, 32'h104, 32'hDEAD_BEEF, t);
    @(negedge clk);
    tests++;
    if (psel !== 4'b0010 || penable !== 1'b0) begin
      fails++;
      $display("FAIL wr_setup: psel=%b penable=%b, required 0010/0", psel, penable);
    end
    tests++;
    if (paddr !== 32'h104 || pwrite !== 1'b1 || pwdata !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL wr_setup_data: paddr=%h pwrite=%b pwdata=%h, required 104/1/deadbeef",
               paddr, pwrite, pwdata);
    end
    @(negedge clk);
    tests++;
    if (psel !== 4'b0010 || penable !== 1'b1 || pwdata !== 32'hDEAD_BEEF || rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL wr_access: psel=%b penable=%b pwdata=%h rsp_valid=%b, required 0010/1/deadbeef/0",
               psel, penable, pwdata, rsp_valid);
    end
    @(negedge clk);
    tests++;
    if (rsp_valid !== 1'b1 || psel !== 4'b0000 || penable !== 1'b0) begin
      fails++;
      $display("FAIL wr_done: rsp_valid=%b psel=%b penable=%b, required 1/0000/0",
               rsp_valid, psel, penable);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_read_wait();
    int t, n;
    wait_cfg[0]  = 3;
    rdata_cfg[0] = 32'h1234_5678;
    drive_cmd(1'b0, 32'h08, 32'hFFFF_FFFF, t);
    @(negedge clk);
    tests++;
    if (psel !== 4'b0001 || pwrite !== 1'b0 || pwdata !== '0) begin
      fails++;
      $display("FAIL rd_setup: psel=%b pwrite=%b pwdata=%h, required 0001/0/0", psel, pwrite, pwdata);
    end
    n = 0;
    @(negedge clk);
    while (penable && n < 50) begin
      n++;
      @(negedge clk);
    end
    tests++;
    if (n !== 4 || rsp_valid !== 1'b1) begin
      fails++;
      $display("FAIL rd_wait_len: access cycles=%0d rsp_valid=%b, required 4/1", n, rsp_valid);
    end
    @(posedge clk);
    #1;
    wait_cfg[0] = 0;
  endtask

  task automatic test_decode_miss();
    int t;
    drive_cmd(1'b1, 32'h500, 32'h55, t);
    @(negedge clk);
    tests++;
    if (rsp_valid !== 1'b1 || psel !== 4'b0000 || penable !== 1'b0) begin
      fails++;
      $display("FAIL miss: rsp_valid=%b psel=%b penable=%b, required 1/0000/0", rsp_valid, psel, penable);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_timeout();
    int t, n;
    wait_cfg[2] = -1;
    drive_cmd(1'b0, 32'h200, 32'h0, t);
    @(negedge clk);
    n = 0;
    @(negedge clk);
    while (penable && n < 50) begin
      n++;
      @(negedge clk);
    end
    tests++;
    if (n !== TMO || psel !== 4'b0000 || rsp_valid !== 1'b1 || rsp_timeout !== 1'b1) begin
      fails++;
      $display("FAIL timeout: access cycles=%0d psel=%b rsp_valid=%b tmo=%b, required %0d/0000/1/1",
               n, psel, rsp_valid, rsp_timeout, TMO);
    end
    wait_cfg[2] = 0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    err_cfg[1]   = 1'b1;
    rdata_cfg[1] = 32'hCAFE_0001;
    drive_cmd(1'b1, 32'h00, 32'hA5A5_A5A5, t1);
    drive_cmd(1'b0, 32'h1FC, 32'h0, t2);
    tests++;
    if (t2 - t1 !== 2) begin
      fails++;
      $display("FAIL b2b_spacing: accept gap=%0d cycles, required 2", t2 - t1);
    end
    @(negedge clk);
    tests++;
    if (psel !== 4'b0010 || penable !== 1'b0 || paddr !== 32'h1FC) begin
      fails++;
      $display("FAIL b2b_setup: psel=%b penable=%b paddr=%h, required 0010/0/1fc", psel, penable, paddr);
    end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    err_cfg[1] = 1'b0;
  endtask

  task automatic test_reset_mid();
    int t;
    exp_t dropped;
    wait_cfg[0] = -1;
    drive_cmd(1'b0, 32'h10, 32'h0, t);
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (penable !== 1'b1 || psel !== 4'b0001) begin
      fails++;
      $display("FAIL rstmid_access: psel=%b penable=%b, required 0001/1", psel, penable);
    end
    #2;
    reset_n = 1'b0;
    #1;
    tests++;
    if (psel !== '0 || penable !== 1'b0 || paddr !== '0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_clear: psel=%b penable=%b paddr=%h rsp_valid=%b rsp_err=%b, required 0",
               psel, penable, paddr, rsp_valid, rsp_err);
    end
    dropped = sb.pop_back();
    wait_cfg[0] = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    drive_cmd(1'b1, 32'h300, 32'h0BAD_F00D, t);
    @(negedge clk);
    tests++;
    if (psel !== 4'b1000 || pwdata !== 32'h0BAD_F00D) begin
      fails++;
      $display("FAIL rstmid_next: psel=%b pwdata=%h, required 1000/0badf00d", psel, pwdata);
    end
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    for (int i = 0; i < NS; i++) begin
      wait_cfg[i]  = 0;
      err_cfg[i]   = 1'b0;
      rdata_cfg[i] = 32'h1000_0000 + i;
    end
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_decode_miss();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge clk);
    tests++;
    if (sb.size() !== 0) begin
      fails++;
      $display("FAIL missing_rsp: %0d responses outstanding, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/apb3_master_mux.md
# apb3_master_mux

Parametrised APB3 bridge master: accepts single read/write commands on a valid/ready request port and runs each as a full APB3 SETUP→ACCESS transfer to one of NSLV slaves selected by address window. Adds wait-state support via PREADY, PSLVERR propagation, decode-error and timeout responses, and back-to-back transfers without an IDLE gap. Sits between the system-side command source and the APB slave array.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- NSLV, 4, number of slaves (1..16)
- BASE_ADDR, 0, start of slave 0 window
- WIN_LOG2, 8, log2 of each slave window in bytes (slave i owns BASE_ADDR + i·2^WIN_LOG2, size 2^WIN_LOG2)
- TIMEOUT, 16, max ACCESS cycles with PREADY low before abort; 0 disables
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when valid&ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  transfer address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_W  read data (0 for writes and errors)
- rsp_err  out  1  PSLVERR, decode miss or timeout
- rsp_timeout  out  1  error was a timeout
- paddr  out  ADDR_W;  pwrite  out  1;  pwdata  out  DATA_W
- psel  out  NSLV  one-hot slave select
- penable  out  1
- prdata  in  NSLV·DATA_W  slave i data at bits [i·DATA_W +: DATA_W]
- pready  in  NSLV;  pslverr  in  NSLV

## Operation
- States: IDLE, SETUP, ACCESS.
- IDLE: cmd_ready=1. On accept, register write/addr/wdata and decode. Hit → SETUP with psel[i]=1, penable=0. Miss → stay IDLE, no psel, rsp_valid=1, rsp_err=1 next cycle.
- SETUP: always → ACCESS next cycle, penable=1.
- ACCESS: sample pready[i] of selected slave. Low → stay, count. High → transfer complete: rsp_valid pulse next cycle, rsp_err=pslverr[i], rsp_rdata=prdata slice i on reads (captured at completion edge), 0 on writes.
- In completing ACCESS cycle cmd_ready=1; accepted hit → SETUP directly (psel moves to new slave, penable drops); accepted miss → IDLE plus error pulse; no command → IDLE, psel=0.
- Timeout (TIMEOUT>0): TIMEOUT consecutive ACCESS cycles with pready low → abort at end of last, psel/penable drop, → IDLE, rsp_err=1, rsp_timeout=1, rsp_rdata=0; late pready ignored.
- paddr, pwrite, pwdata stable from SETUP through final ACCESS cycle; pwdata=0 on reads.
- pready/pslverr/prdata of unselected slaves ignored.

## Timing
- Reset (async, any state): state IDLE, psel=0, penable=0, paddr=0, pwrite=0, pwdata=0, rsp_valid=0, rsp_err=0, rsp_timeout=0, rsp_rdata=0, timeout counter=0. Reset mid-transfer drops it; no response issued.
- All APB and rsp outputs are registered; cmd_ready combinational from state and pready.
- Zero-wait transfer: accept at T, SETUP T+1, ACCESS T+2, rsp_valid T+3. Each wait state adds one cycle.
- Back-to-back zero-wait: one transfer every 2 cycles.
- Decode miss: accept T, rsp_valid T+1.
- Timeout counter width clog2(TIMEOUT+1); cleared on entering ACCESS; saturates, no wrap.
- Address decode: index = (cmd_addr − BASE_ADDR) >> WIN_LOG2; hit iff cmd_addr ≥ BASE_ADDR and index < NSLV; subtraction at ADDR_W bits, underflow is a miss.

## Structure
- Package apb_pkg: state enum (IDLE/SETUP/ACCESS), default width constants, clog2 helper.
- Sub-module apb_addr_decoder: combinational, params ADDR_W/NSLV/BASE_ADDR/WIN_LOG2; outputs one-hot sel and hit. Reused by future interconnect.

## Test plan
- Reset then write 0xDEADBEEF to 0x104, pready=1 → psel=0b0010 T+1, penable T+2, pwdata held, rsp_valid T+3 err=0.
- Read 0x08, slave 0 pready low 3 cycles, prdata=0x1234_5678 → ACCESS 4 cycles, rsp_rdata=0x12345678.
- Command to 0x500 (NSLV=4) → no psel, rsp_valid next cycle, rsp_err=1, rsp_timeout=0.
- Slave 2 pready stuck low, TIMEOUT=16 → abort after 16 ACCESS cycles, rsp_err=1, rsp_timeout=1, psel=0.
- Back-to-back write 0x00 then read 0x1FC, zero wait, pslverr=1 on second → SETUP follows ACCESS directly, second rsp err=1.
- Assert reset_n low during ACCESS → all outputs 0 immediately, no rsp_valid, next command runs normally.
